// File: rtl/memory_scheduler_pkg.sv
// Shared types for the instruction/data memory port scheduler.
// Request bundle, FSM state and port-owner encodings.
package memory_scheduler_pkg;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_type;

  typedef enum logic {
    SCHED_IDLE,
    SCHED_BUSY
  } sched_state_type;

  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } owner_type;

  function automatic mem_req_type pack_req(
    input logic        instr,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    mem_req_type r;
    r.instr = instr;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    return r;
  endfunction

endpackage

// File: rtl/memory_scheduler_if.sv
// One memory channel: single-cycle request pulse and single-cycle
// completion pulse with response data.
interface memory_scheduler_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/memory_scheduler_req_buffer.sv
// One-entry request holding register; a load while full is dropped
// and reported on overflow.
module memory_scheduler_req_buffer
  import memory_scheduler_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  mem_req_type d,
  output logic        full,
  output mem_req_type q,
  output logic        overflow
);

  assign overflow = load & full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load & ~full) begin
      full <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/memory_scheduler.sv
// Shares one memory port between instruction and data requesters:
// data-priority arbitration with starvation guard and a timeout watchdog.
module memory_scheduler
  import memory_scheduler_pkg::*;
#(
  parameter int TIMEOUT      = 1023,
  parameter int TIMEOUT_W    = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  memory_scheduler_if.slave   imemory,
  memory_scheduler_if.slave   dmemory,
  memory_scheduler_if.master  memory,
  input  logic                error_clear,
  output logic                bus_error,
  output logic [31:0]         error_addr
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT);

  sched_state_type state, state_nxt;
  owner_type owner, owner_nxt;
  logic [TIMEOUT_W-1:0] timer, timer_nxt;
  logic [SW-1:0] starve, starve_nxt;

  mem_req_type ireq_in, dreq_in;
  mem_req_type ibuf_q, dbuf_q;
  mem_req_type ireq, dreq, issue_req, mem_req;
  logic ibuf_full, dbuf_full;
  logic iovf, dovf;
  logic ipend, dpend;
  logic issue, imem_win;
  logic iload, dload, iclr, dclr;
  logic done, tmo;
  logic mem_valid;
  logic err_set;
  logic [31:0] err_addr_set;

  assign ireq_in = pack_req(imemory.instr, imemory.addr,
                            imemory.wdata, imemory.wstrb);
  assign dreq_in = pack_req(dmemory.instr, dmemory.addr,
                            dmemory.wdata, dmemory.wstrb);

  // A buffered request is older than a same-cycle pulse, so it goes first.
  assign ireq  = ibuf_full ? ibuf_q : ireq_in;
  assign dreq  = dbuf_full ? dbuf_q : dreq_in;
  assign ipend = ibuf_full | imemory.valid;
  assign dpend = dbuf_full | dmemory.valid;

  assign iclr  = issue & imem_win & ibuf_full;
  assign dclr  = issue & ~imem_win & dbuf_full;
  assign iload = imemory.valid
               & ~(issue & imem_win & ~ibuf_full);
  assign dload = dmemory.valid
               & ~(issue & ~imem_win & ~dbuf_full);

  assign issue_req = imem_win ? ireq : dreq;

  memory_scheduler_req_buffer u_ibuf (
    .clock    (clock),
    .reset    (reset),
    .load     (iload),
    .clear    (iclr),
    .d        (ireq_in),
    .full     (ibuf_full),
    .q        (ibuf_q),
    .overflow (iovf)
  );

  memory_scheduler_req_buffer u_dbuf (
    .clock    (clock),
    .reset    (reset),
    .load     (dload),
    .clear    (dclr),
    .d        (dreq_in),
    .full     (dbuf_full),
    .q        (dbuf_q),
    .overflow (dovf)
  );

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    timer_nxt  = timer;
    starve_nxt = starve;
    issue      = 1'b0;
    imem_win   = 1'b0;
    tmo        = 1'b0;
    done       = 1'b0;
    unique case (state)
      SCHED_IDLE: begin
        if (ipend | dpend) begin
          issue     = 1'b1;
          imem_win  = ipend
                    & (~dpend | (starve == STARVE_MAX));
          owner_nxt = imem_win ? OWN_IMEM : OWN_DMEM;
          state_nxt = SCHED_BUSY;
          timer_nxt = '0;
          if (!imem_win && ipend) begin
            if (starve != STARVE_MAX)
              starve_nxt = starve + 1'b1;
          end else begin
            starve_nxt = '0;
          end
        end
      end
      SCHED_BUSY: begin
        tmo  = ~memory.ready & (timer == TMAX);
        done = memory.ready | tmo;
        if (done) begin
          state_nxt = SCHED_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCHED_IDLE;
      owner     <= OWN_DMEM;
      timer     <= '0;
      starve    <= '0;
      mem_valid <= 1'b0;
      mem_req   <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      timer     <= timer_nxt;
      starve    <= starve_nxt;
      mem_valid <= issue;
      if (issue)
        mem_req <= issue_req;
    end
  end

  assign memory.valid = mem_valid;
  assign memory.instr = mem_req.instr;
  assign memory.addr  = mem_req.addr;
  assign memory.wdata = mem_req.wdata;
  assign memory.wstrb = mem_req.wstrb;

  // A timeout completes the owner with zero data.
  assign imemory.ready = done & (owner == OWN_IMEM);
  assign dmemory.ready = done & (owner == OWN_DMEM);
  assign imemory.rdata = (imemory.ready & memory.ready)
                       ? memory.rdata : '0;
  assign dmemory.rdata = (dmemory.ready & memory.ready)
                       ? memory.rdata : '0;

  assign err_set      = tmo | iovf | dovf;
  assign err_addr_set = tmo  ? mem_req.addr
                      : dovf ? dmemory.addr
                      : imemory.addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_error  <= 1'b0;
      error_addr <= '0;
    end else if (error_clear) begin
      bus_error  <= 1'b0;
      error_addr <= '0;
    end else if (err_set) begin
      bus_error <= 1'b1;
      if (!bus_error)
        error_addr <= err_addr_set;
    end
  end

endmodule
